// File: rtl/tmds_link_sequencer_if.sv
// Link-sequencer bundle between the TMDS encoder/serializer glue and the
// bring-up controller.
//   pll_lock, hpd      raw asynchronous status inputs to the sequencer
//   tmds_video         encoded words from the TMDS encoders, one per channel
//   ser_reset          reset to the serializer OSER10s
//   tmds_internal      words forwarded to the serializer, one per channel
//   link_active        high while the link passes video
//   link_state         IDLE=0, SER_RESET=1, SETTLE=2, ACTIVE=3
//   retrain_count      saturating count of ACTIVE->IDLE aborts
// master: the side that supplies status/video and consumes the link outputs.
// slave:  the sequencer itself.
interface tmds_link_sequencer_if #(
  parameter int NUM_CHANNELS = 3
);
  logic                         pll_lock;
  logic                         hpd;
  logic [NUM_CHANNELS-1:0][9:0] tmds_video;
  logic                         ser_reset;
  logic [NUM_CHANNELS-1:0][9:0] tmds_internal;
  logic                         link_active;
  logic [1:0]                   link_state;
  logic [7:0]                   retrain_count;

  modport master (
    output pll_lock, hpd, tmds_video,
    input  ser_reset, tmds_internal, link_active, link_state, retrain_count
  );

  modport slave (
    input  pll_lock, hpd, tmds_video,
    output ser_reset, tmds_internal, link_active, link_state, retrain_count
  );
endinterface

// File: rtl/tmds_link_sequencer.sv
// Bring-up and recovery controller for the 3-channel OSER10 TMDS serializer,
// clocked by the pixel clock. Holds the serializer in reset until PLL lock
// and a debounced HPD qualify, then sends control-period words for a settle
// window before forwarding encoder words. Any loss of qualification drops
// straight back to IDLE; aborts out of ACTIVE are counted.
// Ports:
//   clk_pixel  pixel clock, the only clock
//   reset      synchronous active-high reset
//   link       tmds_link_sequencer_if.slave (status in, video in/out, state out)
//
// state     | meaning
// ST_IDLE   | serializer in reset, waiting for lock + debounced HPD
// ST_SERRST | serializer reset held for RESET_CYCLES after qualification
// ST_SETTLE | serializer running, BLANK_WORD sent for SETTLE_CYCLES
// ST_ACTIVE | encoder words forwarded to the serializer
module tmds_link_sequencer #(
  parameter int         NUM_CHANNELS  = 3,
  parameter int         RESET_CYCLES  = 16,
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         HPD_DEBOUNCE  = 4096,
  parameter logic [9:0] BLANK_WORD    = 10'h354
) (
  input logic                  clk_pixel,
  input logic                  reset,
  tmds_link_sequencer_if.slave link
);

  localparam int PHASE_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int DW = $clog2(HPD_DEBOUNCE + 1);
  localparam logic [PW-1:0] RESET_LAST  = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_FULL    = DW'(HPD_DEBOUNCE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERRST = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  logic                         lock_meta, lock_s;
  logic                         hpd_meta, hpd_s;
  logic [DW-1:0]                deb_cnt;
  logic                         hpd_ok, qual, go_active;
  state_t                       state;
  logic [PW-1:0]                phase_cnt;
  logic                         ser_reset_q, link_active_q;
  logic [7:0]                   retrain_q;
  logic [NUM_CHANNELS-1:0][9:0] tmds_q;

  // Synchronizers and HPD debounce. Any synchronized-low cycle restarts the
  // full debounce window.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      hpd_meta  <= 1'b0;
      hpd_s     <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      lock_meta <= link.pll_lock;
      lock_s    <= lock_meta;
      hpd_meta  <= link.hpd;
      hpd_s     <= hpd_meta;
      if (!hpd_s)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_FULL)
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign hpd_ok = (deb_cnt == DEB_FULL);
  assign qual   = lock_s & hpd_ok;

  // Next state is ACTIVE: lets the first video word land on the same edge
  // that link_active rises.
  assign go_active = qual & ((state == ST_ACTIVE) ||
                             (state == ST_SETTLE && phase_cnt == SETTLE_LAST));

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase_cnt     <= '0;
      ser_reset_q   <= 1'b1;
      link_active_q <= 1'b0;
      retrain_q     <= 8'd0;
      tmds_q        <= {NUM_CHANNELS{BLANK_WORD}};
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++)
        tmds_q[ch] <= go_active ? link.tmds_video[ch] : BLANK_WORD;

      if (!qual) begin
        // Abort has priority over any terminal count reached this cycle.
        if (state == ST_ACTIVE && retrain_q != 8'hFF)
          retrain_q <= retrain_q + 8'd1;
        state         <= ST_IDLE;
        phase_cnt     <= '0;
        ser_reset_q   <= 1'b1;
        link_active_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state       <= ST_SERRST;
            phase_cnt   <= '0;
            ser_reset_q <= 1'b1;
          end
          ST_SERRST: begin
            if (phase_cnt == RESET_LAST) begin
              state       <= ST_SETTLE;
              phase_cnt   <= '0;
              ser_reset_q <= 1'b0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          ST_SETTLE: begin
            if (phase_cnt == SETTLE_LAST) begin
              state         <= ST_ACTIVE;
              link_active_q <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          ST_ACTIVE: begin
            link_active_q <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign link.ser_reset     = ser_reset_q;
  assign link.link_active   = link_active_q;
  assign link.link_state    = state;
  assign link.retrain_count = retrain_q;
  assign link.tmds_internal = tmds_q;

endmodule
